// File: rtl/y86_alu_pkg.sv
// Shared Y86 ALU encodings: ALU function codes, branch/cmov condition codes,
// condition-code bit positions and the flag reset value.
package y86_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_XOR = 4'd3
    } alu_fun_e;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'd0,
        C_LE     = 4'd1,
        C_L      = 4'd2,
        C_E      = 4'd3,
        C_NE     = 4'd4,
        C_GE     = 4'd5,
        C_G      = 4'd6
    } cond_fun_e;

    localparam int unsigned CC_ZF = 2;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    // Evaluates a Y86 condition against a {ZF,SF,OF} flag triple; unknown codes give 0.
    function automatic logic eval_cond(input logic [3:0] fn, input logic [2:0] cc);
        logic w_lt;
        logic w_res;
        w_lt  = cc[CC_SF] ^ cc[CC_OF];
        w_res = 1'b0;
        case (fn)
            C_ALWAYS: w_res = 1'b1;
            C_LE:     w_res = w_lt | cc[CC_ZF];
            C_L:      w_res = w_lt;
            C_E:      w_res = cc[CC_ZF];
            C_NE:     w_res = ~cc[CC_ZF];
            C_GE:     w_res = ~w_lt;
            C_G:      w_res = ~w_lt & ~cc[CC_ZF];
            default:  w_res = 1'b0;
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/cc_flag_gen.sv
// Combinational ZF/SF/OF derivation from the ALU operands and its result.
// Subtraction follows the Y86 convention res = b - a.
module cc_flag_gen
    import y86_alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [3:0]       fun,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] res,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    logic w_a_s;
    logic w_b_s;
    logic w_r_s;
    logic w_unused;

    assign w_a_s    = a[WIDTH-1];
    assign w_b_s    = b[WIDTH-1];
    assign w_r_s    = res[WIDTH-1];
    // Only operand sign bits matter for overflow detection.
    assign w_unused = &{1'b0, a[WIDTH-2:0], b[WIDTH-2:0]};

    assign zf = (res == '0);
    assign sf = w_r_s;

    always_comb begin
        of = 1'b0;
        case (fun)
            ALU_ADD: of = (w_a_s == w_b_s) & (w_r_s != w_a_s);
            ALU_SUB: of = (w_a_s != w_b_s) & (w_r_s != w_b_s);
            default: of = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_cc_unit.sv
// Y86 condition-code register with update counter and condition evaluation.
// Define CC_BYPASS_EN to let cond see flags being written in the same cycle.
module alu_cc_unit
    import y86_alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [3:0]       alu_fun,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             set_cc,
    input  logic             cc_stall,
    input  logic [3:0]       cond_fun,
    output logic [2:0]       cc_out,
    output logic             cond,
    output logic             cc_updated,
    output logic             fun_err,
    output logic [CNT_W-1:0] upd_count
);

    logic [2:0]       r_cc;
    logic             r_upd;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_try;
    logic             w_fun_ok;
    logic             w_upd;
    logic             w_zf;
    logic             w_sf;
    logic             w_of;
    logic [2:0]       w_new_cc;
    logic [2:0]       w_cond_cc;

    cc_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .fun (alu_fun),
        .a   (alu_a),
        .b   (alu_b),
        .res (alu_res),
        .zf  (w_zf),
        .sf  (w_sf),
        .of  (w_of)
    );

    assign w_new_cc = {w_zf, w_sf, w_of};
    assign w_try    = alu_valid & set_cc & ~cc_stall;
    assign w_fun_ok = (alu_fun <= ALU_XOR);
    // A reset in the same cycle cancels the write, so it is not treated as pending.
    assign w_upd    = ~rst & w_try & w_fun_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc  <= CC_RESET;
            r_upd <= 1'b0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_upd <= w_upd;
            r_err <= w_try & ~w_fun_ok;
            if (w_upd) begin
                r_cc <= w_new_cc;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef CC_BYPASS_EN
    assign w_cond_cc = w_upd ? w_new_cc : r_cc;
`else
    assign w_cond_cc = r_cc;
`endif

    assign cond       = eval_cond(cond_fun, w_cond_cc);
    assign cc_out     = r_cc;
    assign cc_updated = r_upd;
    assign fun_err    = r_err;
    assign upd_count  = r_cnt;

endmodule

// File: tb/tb_alu_cc_unit.sv
// Scoreboard bench for alu_cc_unit: expected register state is queued when
// inputs are applied and compared one clock later.
module tb_alu_cc_unit;

    localparam int W  = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [3:0]    alu_fun;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_res;
    logic          set_cc;
    logic          cc_stall;
    logic [3:0]    cond_fun;
    logic [2:0]    cc_out;
    logic          cond;
    logic          cc_updated;
    logic          fun_err;
    logic [CW-1:0] upd_count;

    always #5 clk = ~clk;

    alu_cc_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_fun    (alu_fun),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_res    (alu_res),
        .set_cc     (set_cc),
        .cc_stall   (cc_stall),
        .cond_fun   (cond_fun),
        .cc_out     (cc_out),
        .cond       (cond),
        .cc_updated (cc_updated),
        .fun_err    (fun_err),
        .upd_count  (upd_count)
    );

    typedef struct packed {
        logic [2:0]    cc;
        logic          upd;
        logic          err;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t          sb[$];
    obs_t          got;
    obs_t          ex;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [2:0]    m_cc  = 3'b100;
    logic [CW-1:0] m_cnt = '0;
    logic          exp_cond;

    localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;

    // Overflow from a widened true sum/difference rather than sign-bit rules.
    function automatic logic [2:0] ref_flags(input logic [3:0] fn, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] res);
        logic [W:0] s;
        logic       of;
        of = 1'b0;
        s  = '0;
        if (fn == 4'd0) begin
            s  = {a[W-1], a} + {b[W-1], b};
            of = s[W] ^ s[W-1];
        end else if (fn == 4'd1) begin
            s  = {b[W-1], b} - {a[W-1], a};
            of = s[W] ^ s[W-1];
        end
        return {res == '0, res[W-1], of};
    endfunction

    function automatic logic ref_cond(input logic [3:0] cf, input logic [2:0] f);
        logic zf, sf, of;
        {zf, sf, of} = f;
        if (cf == 4'd0) return 1'b1;
        if (cf == 4'd1) return (sf != of) || zf;
        if (cf == 4'd2) return sf != of;
        if (cf == 4'd3) return zf;
        if (cf == 4'd4) return !zf;
        if (cf == 4'd5) return sf == of;
        if (cf == 4'd6) return (sf == of) && !zf;
        return 1'b0;
    endfunction

    task automatic set_in(input logic r, input logic v, input logic sc, input logic st,
                          input logic [3:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic [3:0] cf);
        logic       upd;
        logic       err;
        logic [2:0] nf;
        logic [2:0] src;
        rst = r; alu_valid = v; set_cc = sc; cc_stall = st;
        alu_fun = fn; alu_a = a; alu_b = b; alu_res = res; cond_fun = cf;
        upd = !r && v && sc && !st && (fn < 4'd4);
        err = !r && v && sc && !st && (fn > 4'd3);
        nf  = ref_flags(fn, a, b, res);
        src = m_cc;
`ifdef CC_BYPASS_EN
        if (upd) src = nf;
`endif
        exp_cond = ref_cond(cf, src);
        if (r) begin
            m_cc  = 3'b100;
            m_cnt = '0;
        end else if (upd) begin
            m_cc = nf;
            if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        sb.push_back('{cc: m_cc, upd: upd, err: err, cnt: m_cnt});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] cf);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, '0, '0, '0, cf);
    endtask

    task automatic test_reset;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, '0, '0, '0, 4'd3);
        tick();
        got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL reset got=%h exp=%h", got, ex); end
        n_checks++;
        if (cc_out !== 3'b100 || upd_count !== '0) begin
            n_errors++; $display("FAIL reset_const cc=%b cnt=%0d exp cc=100 cnt=0", cc_out, upd_count);
        end
        idle(4'd3); #1;
        n_checks++;
        if (cond !== 1'b1) begin n_errors++; $display("FAIL reset_cond_e got=%b exp=1", cond); end
        tick(); void'(sb.pop_front());
    endtask

    task automatic test_xor;
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, MAXP, MAXP, '0, 4'd0);
        tick();
        got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL xor got=%h exp=%h", got, ex); end
        n_checks++;
        if (cc_out !== 3'b100 || cc_updated !== 1'b1 || upd_count !== CW'(1)) begin
            n_errors++; $display("FAIL xor_const cc=%b upd=%b cnt=%0d exp 100/1/1", cc_out, cc_updated, upd_count);
        end
    endtask

    task automatic test_add;
        logic [3:0] cfs[3] = '{4'd2, 4'd1, 4'd6};
        logic       exps[3] = '{1'b0, 1'b0, 1'b1};
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 4'd0);
        tick();
        got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL add got=%h exp=%h", got, ex); end
        n_checks++;
        if (cc_out !== 3'b011) begin n_errors++; $display("FAIL add_cc got=%b exp=011", cc_out); end
        for (int i = 0; i < 3; i++) begin
            idle(cfs[i]); #1;
            n_checks++;
            if (cond !== exps[i]) begin
                n_errors++; $display("FAIL add_cond fun=%0d got=%b exp=%b", cfs[i], cond, exps[i]);
            end
            tick(); void'(sb.pop_front());
        end
        n_checks++;
        if (cc_updated !== 1'b0) begin n_errors++; $display("FAIL add_pulse got=%b exp=0", cc_updated); end
    endtask

    task automatic test_sub;
        logic [3:0] cfs[2] = '{4'd2, 4'd5};
        logic       exps[2] = '{1'b1, 1'b0};
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 64'd1, MINN, MAXP, 4'd0);
        tick();
        got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL sub got=%h exp=%h", got, ex); end
        n_checks++;
        if (cc_out !== 3'b001) begin n_errors++; $display("FAIL sub_cc got=%b exp=001", cc_out); end
        for (int i = 0; i < 2; i++) begin
            idle(cfs[i]); #1;
            n_checks++;
            if (cond !== exps[i]) begin
                n_errors++; $display("FAIL sub_cond fun=%0d got=%b exp=%b", cfs[i], cond, exps[i]);
            end
            tick(); void'(sb.pop_front());
        end
    endtask

    task automatic test_stall_err;
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, '0, '0, '0, 4'd0);
        tick();
        got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL stall got=%h exp=%h", got, ex); end
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, '0, '0, '0, 4'd0);
        tick();
        got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL fun_err got=%h exp=%h", got, ex); end
        n_checks++;
        if (fun_err !== 1'b1 || cc_out !== 3'b001 || upd_count !== CW'(3)) begin
            n_errors++; $display("FAIL fun_err_const err=%b cc=%b cnt=%0d exp 1/001/3", fun_err, cc_out, upd_count);
        end
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, '0, '0, '0, 4'd0);
        tick();
        got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL no_valid got=%h exp=%h", got, ex); end
    endtask

    task automatic test_bypass;
        logic want;
`ifdef CC_BYPASS_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 64'd1, '1, '0, 4'd3);
        #1;
        n_checks++;
        if (cond !== want) begin n_errors++; $display("FAIL bypass_cond got=%b exp=%b", cond, want); end
        tick();
        got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL bypass_upd got=%h exp=%h", got, ex); end
    endtask

    task automatic test_rst_with_update;
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 4'd0);
        tick();
        got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
        if (got !== ex) begin n_errors++; $display("FAIL rst_upd got=%h exp=%h", got, ex); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 18; i++) begin
            set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 64'(i), 64'(i + 1), 64'(i) & 64'(i + 1), 4'd0);
            tick();
            got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
            if (got !== ex) begin n_errors++; $display("FAIL sat[%0d] got=%h exp=%h", i, got, ex); end
        end
        n_checks++;
        if (upd_count !== {CW{1'b1}}) begin
            n_errors++; $display("FAIL sat_const got=%0d exp=%0d", upd_count, {CW{1'b1}});
        end
    endtask

    task automatic test_back_to_back_random;
        logic [3:0]   fn;
        logic [W-1:0] a, b, res;
        for (int i = 0; i < 40; i++) begin
            fn = 4'($urandom_range(0, 5));
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 5) == 0) ? a : {$urandom, $urandom};
            case (fn)
                4'd0:    res = a + b;
                4'd1:    res = b - a;
                4'd2:    res = a & b;
                4'd3:    res = a ^ b;
                default: res = {$urandom, $urandom};
            endcase
            set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
                   ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0),
                   fn, a, b, res, 4'($urandom_range(0, 8)));
            #1;
            n_checks++;
            if (cond !== exp_cond) begin
                n_errors++; $display("FAIL rnd_cond[%0d] got=%b exp=%b", i, cond, exp_cond);
            end
            tick();
            got = {cc_out, cc_updated, fun_err, upd_count}; ex = sb.pop_front(); n_checks++;
            if (got !== ex) begin n_errors++; $display("FAIL rnd[%0d] got=%h exp=%h", i, got, ex); end
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_add();
        test_sub();
        test_stall_err();
        test_bypass();
        test_rst_with_update();
        test_saturation();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
